bank_req_demux: RTL

//  Write/request side of the 4-bank memory: accepts one request stream and dispatches each request
//  to one of 4 banks, decoded from address bits [ADDR_WIDTH-1:ADDR_WIDTH-2].

---
 rtl/bank_req_demux_if.sv | 29 ++
 rtl/bank_req_demux.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bank_req_demux_if.sv
// Request/bank bus of the 4-bank write/request demux, including the read-return select.
// Parameters must match the bank_req_demux instance that uses it.
interface bank_req_demux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_we;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [3:0]            o_bank_valid;
  logic [3:0]            i_bank_ready;
  logic                  o_bank_we;
  logic [ADDR_WIDTH-3:0] o_bank_addr;
  logic [DATA_WIDTH-1:0] o_bank_wdata;
  logic [1:0]            o_rsel;
  logic                  o_rsel_valid;

  modport slave (
    input  i_valid, i_we, i_addr, i_wdata, i_bank_ready,
    output o_ready, o_bank_valid, o_bank_we, o_bank_addr, o_bank_wdata, o_rsel, o_rsel_valid
  );

  modport master (
    output i_valid, i_we, i_addr, i_wdata, i_bank_ready,
    input  o_ready, o_bank_valid, o_bank_we, o_bank_addr, o_bank_wdata, o_rsel, o_rsel_valid
  );
endinterface

// File: rtl/bank_req_demux.sv
// Dispatches one request stream to 4 banks through a single registered stage and tracks
// which bank each read returns from. Define BANK_REQ_STATS_EN to add per-bank handshake counters.
module bank_req_demux #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  bank_req_demux_if.slave       bus
`ifdef BANK_REQ_STATS_EN
  ,
  output logic [63:0]           o_bank_cnt
`endif
);

  localparam int BANK_AW = ADDR_WIDTH - 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [3:0]            bank_valid_q, bank_valid_d;
  logic [1:0]            bank_idx_q, bank_idx_d;
  logic                  we_q, we_d;
  logic [BANK_AW-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [READ_LATENCY-1:0]      rsel_v_q, rsel_v_d;
  logic [READ_LATENCY-1:0][1:0] rsel_b_q, rsel_b_d;

  logic       bank_hs;
  logic       ready;
  logic       accept;
  logic [1:0] req_bank;

  assign req_bank = bus.i_addr[ADDR_WIDTH-1 -: 2];
  assign bank_hs  = (state_q == ST_HOLD) && bus.i_bank_ready[bank_idx_q];
  // Ready passes straight through from the held bank so a draining slot can refill with no bubble.
  assign ready    = (state_q == ST_IDLE) || bank_hs;
  assign accept   = bus.i_valid && ready;

  always_comb begin
    state_d      = state_q;
    bank_valid_d = bank_valid_q;
    bank_idx_d   = bank_idx_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if (accept) begin
      state_d      = ST_HOLD;
      bank_valid_d = 4'b0001 << req_bank;
      bank_idx_d   = req_bank;
      we_d         = bus.i_we;
      addr_d       = bus.i_addr[BANK_AW-1:0];
      wdata_d      = bus.i_wdata;
    end else if (bank_hs) begin
      state_d      = ST_IDLE;
      bank_valid_d = 4'b0000;
    end
  end

  always_comb begin
    rsel_v_d    = rsel_v_q;
    rsel_b_d    = rsel_b_q;
    rsel_v_d[0] = bank_hs && !we_q;
    rsel_b_d[0] = bank_idx_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rsel_v_d[i] = rsel_v_q[i-1];
      rsel_b_d[i] = rsel_b_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      bank_valid_q <= '0;
      bank_idx_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsel_v_q     <= '0;
      rsel_b_q     <= '0;
    end else begin
      state_q      <= state_d;
      bank_valid_q <= bank_valid_d;
      bank_idx_q   <= bank_idx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsel_v_q     <= rsel_v_d;
      rsel_b_q     <= rsel_b_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_bank_valid = bank_valid_q;
  assign bus.o_bank_we    = we_q;
  assign bus.o_bank_addr  = addr_q;
  assign bus.o_bank_wdata = wdata_q;
  assign bus.o_rsel       = rsel_b_q[READ_LATENCY-1];
  assign bus.o_rsel_valid = rsel_v_q[READ_LATENCY-1];

`ifdef BANK_REQ_STATS_EN
  logic [3:0][15:0] cnt_q, cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (bank_hs && (cnt_q[bank_idx_q] != 16'hFFFF)) begin
      cnt_d[bank_idx_q] = cnt_q[bank_idx_q] + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_bank_cnt = cnt_q;
`endif

endmodule
